camera_pattern_generator: RTL

//  Synthetic Bayer-raw source emulating the camera sensor output on the Camera_PIXCLK domain.

---
 rtl/camera_pattern_generator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/camera_pattern_generator.sv
// Synthetic Bayer-raw frame source on the Camera_PIXCLK domain, standing in for the
// sensor pins ahead of the camera data controller.
module camera_pattern_generator #(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 64,
  parameter int V_ACTIVE = 960,
  parameter int FV_LEAD  = 8,
  parameter int FV_TRAIL = 8,
  parameter int V_BLANK  = 4096
) (
  input  logic        Camera_PIXCLK,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic [1:0]  iPattern_Sel,
  input  logic [9:0]  iConst_Value,
  output logic [9:0]  oCamera_Data,
  output logic        oFrame_Valid,
  output logic        oLine_Valid,
  output logic [31:0] oFrame_Count
);

  localparam int M_A     = (H_ACTIVE > H_BLANK)  ? H_ACTIVE : H_BLANK;
  localparam int M_B     = (FV_LEAD  > FV_TRAIL) ? FV_LEAD  : FV_TRAIL;
  localparam int M_C     = (M_A > M_B) ? M_A : M_B;
  localparam int CNT_MAX = (M_C > V_BLANK) ? M_C : V_BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BAR_W   = H_ACTIVE / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_VBLANK, S_FV_LEAD, S_ACTIVE, S_HBLANK, S_FV_TRAIL
  } state_t;

  state_t      state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [11:0] x, y, nxt_x, nxt_y;
  logic [1:0]  pat, nxt_pat;
  logic        frame_start;
  logic [2:0]  bar;
  logic        comp_on;
  logic [9:0]  pix_nxt;

  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt - 1'b1;
    nxt_x       = x;
    nxt_y       = y;
    nxt_pat     = pat;
    frame_start = 1'b0;
    if (!Enable) begin
      nxt_state = S_IDLE;
      nxt_cnt   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          nxt_state = S_VBLANK;
          nxt_cnt   = CW'(V_BLANK - 1);
        end
        S_VBLANK: if (cnt == '0) begin
          nxt_state   = S_FV_LEAD;
          nxt_cnt     = CW'(FV_LEAD - 1);
          nxt_x       = '0;
          nxt_y       = '0;
          nxt_pat     = iPattern_Sel;
          frame_start = 1'b1;
        end
        S_FV_LEAD: if (cnt == '0) begin
          nxt_state = S_ACTIVE;
          nxt_cnt   = CW'(H_ACTIVE - 1);
        end
        S_ACTIVE: begin
          if (cnt == '0) begin
            if (y == 12'(V_ACTIVE - 1)) begin
              nxt_state = S_FV_TRAIL;
              nxt_cnt   = CW'(FV_TRAIL - 1);
            end else begin
              nxt_state = S_HBLANK;
              nxt_cnt   = CW'(H_BLANK - 1);
              nxt_y     = y + 12'd1;
              nxt_x     = '0;
            end
          end else begin
            nxt_x = x + 12'd1;
          end
        end
        S_HBLANK: if (cnt == '0) begin
          nxt_state = S_ACTIVE;
          nxt_cnt   = CW'(H_ACTIVE - 1);
        end
        S_FV_TRAIL: if (cnt == '0) begin
          nxt_state = S_VBLANK;
          nxt_cnt   = CW'(V_BLANK - 1);
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Pixel is computed for the coordinates the next cycle will present, so data
  // lines up with the registered LV.
  always_comb begin
    bar     = 3'(nxt_x / 12'(BAR_W));
    comp_on = 1'b0;
    pix_nxt = '0;
    unique case ({nxt_y[0], nxt_x[0]})
      2'b01:   comp_on = bar[2];
      2'b10:   comp_on = bar[0];
      default: comp_on = bar[1];
    endcase
    unique case (nxt_pat)
      2'd0:    pix_nxt = comp_on ? 10'h3FF : 10'h000;
      2'd1:    pix_nxt = nxt_x[9:0];
      2'd2:    pix_nxt = (nxt_x[3] ^ nxt_y[3]) ? 10'h3FF : 10'h000;
      default: pix_nxt = iConst_Value;
    endcase
  end

  always_ff @(posedge Camera_PIXCLK or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      x            <= '0;
      y            <= '0;
      pat          <= '0;
      oCamera_Data <= '0;
      oFrame_Valid <= 1'b0;
      oLine_Valid  <= 1'b0;
      oFrame_Count <= '0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      x            <= nxt_x;
      y            <= nxt_y;
      pat          <= nxt_pat;
      oFrame_Valid <= (nxt_state != S_IDLE) && (nxt_state != S_VBLANK);
      oLine_Valid  <= (nxt_state == S_ACTIVE);
      oCamera_Data <= (nxt_state == S_ACTIVE) ? pix_nxt : 10'h000;
      if (!Enable)
        oFrame_Count <= '0;
      else if (frame_start)
        oFrame_Count <= oFrame_Count + 32'd1;
    end
  end

endmodule
